// File: rtl/urna_booth_arbiter.sv
// rtl/urna_booth_arbiter.sv - round-robin ballot booth arbiter with shared tallies and session sequencer
// Optional feature macro: URNA_ARB_SATURATE_EN (tally counters stick at all-ones instead of wrapping).
module urna_booth_arbiter #(
    parameter int NUM_BOOTHS = 4,
    parameter int CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      finish,
    input  logic [NUM_BOOTHS-1:0]     req,
    input  logic [2*NUM_BOOTHS-1:0]   code,
    output logic [NUM_BOOTHS-1:0]     ack,
    output logic [1:0]                session,
    output logic                      busy,
    output logic [CNT_W-1:0]          total_c1,
    output logic [CNT_W-1:0]          total_c2,
    output logic [CNT_W-1:0]          total_null,
    output logic                      total_valid,
    output logic                      overflow
);

    localparam int PTR_W = (NUM_BOOTHS > 2) ? $clog2(NUM_BOOTHS) : 1;
    localparam logic [PTR_W:0] NB = (PTR_W + 1)'(NUM_BOOTHS);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_OPEN   = 2'b01;
    localparam logic [1:0] S_DRAIN  = 2'b10;
    localparam logic [1:0] S_CLOSED = 2'b11;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [PTR_W-1:0]      winner;
    logic [PTR_W-1:0]      idx;
    logic [PTR_W:0]        cand;
    logic [PTR_W:0]        nxt_sum;
    logic                  grant_valid;
    logic [1:0]            win_code;
    logic [NUM_BOOTHS-1:0] eligible;
    logic [NUM_BOOTHS-1:0] grant_vec;
    logic [NUM_BOOTHS-1:0] pending;
    logic [CNT_W-1:0]      cnt_c1;
    logic [CNT_W-1:0]      cnt_c2;
    logic [CNT_W-1:0]      cnt_null;
    logic [CNT_W-1:0]      cnt_sel;
    logic [CNT_W-1:0]      cnt_bumped;
    logic                  open_entry;
    logic                  close_entry;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef URNA_ARB_SATURATE_EN
        bump = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
`else
        bump = v + 1'b1;
`endif
    endfunction

    // A booth just acked is masked so it cannot be granted twice back to back.
    always_comb begin
        eligible = '0;
        if (state == S_OPEN) begin
            eligible = req & ~ack;
        end else if (state == S_DRAIN) begin
            eligible = req & pending & ~ack;
        end
    end

    // Scan offsets from far to near so the nearest eligible index at/after ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        ptr_nxt     = ptr;
        win_code    = 2'b00;
        cand        = '0;
        idx         = '0;
        nxt_sum     = '0;
        for (int i = NUM_BOOTHS - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (cand >= NB) begin
                cand = cand - NB;
            end
            idx = cand[PTR_W-1:0];
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                winner      = idx;
                win_code    = code[{idx, 1'b0} +: 2];
                nxt_sum     = {1'b0, idx} + 1'b1;
                ptr_nxt     = (nxt_sum == NB) ? '0 : nxt_sum[PTR_W-1:0];
            end
        end
        grant_vec         = '0;
        grant_vec[winner] = grant_valid;
    end

    always_comb begin
        case (win_code)
            2'b01:   cnt_sel = cnt_c1;
            2'b10:   cnt_sel = cnt_c2;
            default: cnt_sel = cnt_null;
        endcase
        cnt_bumped = bump(cnt_sel);
    end

    assign open_entry  = ((state == S_IDLE) || (state == S_CLOSED)) && start;
    assign close_entry = (state == S_DRAIN) && (pending == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // finish only matters in OPEN, so it naturally wins over start there.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_OPEN;
            S_OPEN:   if (finish) state_nxt = S_DRAIN;
            S_DRAIN:  if (pending == '0) state_nxt = S_CLOSED;
            S_CLOSED: if (start) state_nxt = S_OPEN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        session     = state;
        busy        = (state == S_OPEN) || (state == S_DRAIN);
        total_valid = (state == S_CLOSED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack        <= '0;
            ptr        <= '0;
            pending    <= '0;
            cnt_c1     <= '0;
            cnt_c2     <= '0;
            cnt_null   <= '0;
            overflow   <= 1'b0;
            total_c1   <= '0;
            total_c2   <= '0;
            total_null <= '0;
        end else begin
            ack <= grant_vec;

            if (open_entry) begin
                ptr      <= '0;
                cnt_c1   <= '0;
                cnt_c2   <= '0;
                cnt_null <= '0;
                overflow <= 1'b0;
            end else if (grant_valid) begin
                ptr <= ptr_nxt;
                case (win_code)
                    2'b01:   cnt_c1   <= cnt_bumped;
                    2'b10:   cnt_c2   <= cnt_bumped;
                    default: cnt_null <= cnt_bumped;
                endcase
                if (cnt_bumped == {CNT_W{1'b1}}) begin
                    overflow <= 1'b1;
                end
            end

            // The winner of the finish edge is already served, so it never enters pending.
            if (state == S_OPEN && finish) begin
                pending <= req & ~ack & ~grant_vec;
            end else if (state == S_DRAIN) begin
                pending <= pending & req & ~grant_vec;
            end else begin
                pending <= '0;
            end

            if (close_entry) begin
                total_c1   <= cnt_c1;
                total_c2   <= cnt_c2;
                total_null <= cnt_null;
            end
        end
    end

endmodule

// File: tb/tb_urna_booth_arbiter.sv
// tb/tb_urna_booth_arbiter.sv - randomized and directed check of urna_booth_arbiter against a behavioural model
module tb_urna_booth_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           finish;
    logic [N-1:0]   req;
    logic [2*N-1:0] code;
    logic [N-1:0]   ack;
    logic [1:0]     session;
    logic           busy;
    logic [W-1:0]   total_c1;
    logic [W-1:0]   total_c2;
    logic [W-1:0]   total_null;
    logic           total_valid;
    logic           overflow;

    urna_booth_arbiter #(.NUM_BOOTHS(N), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .req(req), .code(code), .ack(ack), .session(session), .busy(busy),
        .total_c1(total_c1), .total_c2(total_c2), .total_null(total_null),
        .total_valid(total_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         m_state;
    logic [N-1:0] m_ack;
    logic [N-1:0] m_pend;
    int         m_ptr;
    int         m_cnt [3];
    int         m_tot [3];
    logic       m_ovf;
    int         left  [N];
    logic [1:0] bcode [N];
    logic       rnd_en;
    int         exp_null;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cat(input logic [1:0] c);
        if (c == 2'b01) return 0;
        if (c == 2'b10) return 1;
        return 2;
    endfunction

    function automatic int sum_left();
        int s = 0;
        for (int i = 0; i < N; i++) s += left[i];
        return s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ack = '0; m_pend = '0; m_ptr = 0; m_ovf = 1'b0;
        for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_tot[k] = 0; end
    endtask

    // One clock edge of the session rules, evaluated on the inputs the DUT is about to sample.
    task automatic model_edge();
        logic [N-1:0] elig;
        logic [N-1:0] wbit;
        int w;
        int c;
        int nv;
        elig = '0; wbit = '0; w = -1;
        if (m_state == 1) elig = req & ~m_ack;
        else if (m_state == 2) elig = req & m_pend & ~m_ack;
        for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
            wbit[w] = 1'b1;
            c  = cat(bcode[w]);
            nv = m_cnt[c] + 1;
`ifdef URNA_ARB_SATURATE_EN
            if (nv > MAXV) nv = MAXV;
`else
            if (nv > MAXV) nv = 0;
`endif
            m_cnt[c] = nv;
            if (nv == MAXV) m_ovf = 1'b1;
            m_ptr = (w + 1) % N;
            left[w]--;
        end
        case (m_state)
            1: if (finish) begin m_state = 2; m_pend = req & ~m_ack & ~wbit; end
            2: if (m_pend == '0) begin
                   m_state = 3;
                   for (int k = 0; k < 3; k++) m_tot[k] = m_cnt[k];
               end else begin
                   m_pend = m_pend & req & ~wbit;
               end
            default: if (start) begin
                   m_state = 1; m_ptr = 0; m_ovf = 1'b0;
                   for (int k = 0; k < 3; k++) m_cnt[k] = 0;
               end
        endcase
        m_ack = wbit;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rnd_en && left[i] == 0 && $urandom_range(0, 2) == 0) begin
                left[i]  = 1;
                bcode[i] = 2'($urandom_range(0, 3));
            end
            req[i]         = (left[i] > 0) && !m_ack[i];
            code[2*i +: 2] = bcode[i];
        end
    endtask

    task automatic check_all();
        chk("ack", 32'(ack), 32'(m_ack));
        chk("session", 32'(session), 32'(m_state));
        chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
        chk("total_valid", 32'(total_valid), 32'(m_state == 3));
        chk("total_c1", 32'(total_c1), 32'(m_tot[0]));
        chk("total_c2", 32'(total_c2), 32'(m_tot[1]));
        chk("total_null", 32'(total_null), 32'(m_tot[2]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        drive_inputs();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_to_closed();
        for (int c = 0; c < 60 && m_state != 3; c++) step();
        chk("reach_closed", 32'(session), 32'd3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; rnd_en = 1'b0;
        req = '0; code = '0;
        for (int i = 0; i < N; i++) begin left[i] = 0; bcode[i] = 2'b00; end
        model_reset();
        #12;
        check_all();
        chk("reset_session", 32'(session), 32'd0);
        rst = 1'b0;

        // Single C1 vote from booth 2.
        start = 1'b1; step(); start = 1'b0;
        chk("open_session", 32'(session), 32'd1);
        left[2] = 1; bcode[2] = 2'b01;
        step();
        chk("b2_ack", 32'(ack), 32'b0100);
        step();
        chk("b2_ack_one_cycle", 32'(ack), 32'b0000);
        finish = 1'b1; step(); finish = 1'b0;
        run_to_closed();
        chk("tp1_c1", 32'(total_c1), 32'd1);
        chk("tp1_valid", 32'(total_valid), 32'd1);

        // Four booths, all C2, served in index order.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < N; i++) begin left[i] = 1; bcode[i] = 2'b10; end
        for (int i = 0; i < N; i++) begin
            step();
            chk("rr_order", 32'(ack), 32'(1 << i));
        end
        finish = 1'b1; step(); finish = 1'b0;
        run_to_closed();
        chk("tp2_c2", 32'(total_c2), 32'd4);

        // finish together with requests from booths 1 and 3.
        start = 1'b1; step(); start = 1'b0;
        left[1] = 1; bcode[1] = 2'b01; left[3] = 1; bcode[3] = 2'b11;
        finish = 1'b1; step(); finish = 1'b0;
        chk("tp3_edge_grant", 32'(ack), 32'b0010);
        chk("tp3_drain", 32'(session), 32'd2);
        left[0] = 1; bcode[0] = 2'b10;
        step();
        chk("tp3_drain_grant", 32'(ack), 32'b1000);
        step();
        chk("tp3_closed", 32'(session), 32'd3);
        chk("tp3_total", 32'(total_c1) + 32'(total_c2) + 32'(total_null), 32'd2);
        left[0] = 0;

        // 256 null votes drive the null counter through all-ones.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < N; i++) begin left[i] = 64; bcode[i] = (i % 2 == 0) ? 2'b00 : 2'b11; end
        for (int c = 0; c < 1500 && sum_left() > 0; c++) step();
        chk("tp4_drained", 32'(sum_left()), 32'd0);
        finish = 1'b1; step(); finish = 1'b0;
        run_to_closed();
`ifdef URNA_ARB_SATURATE_EN
        exp_null = MAXV;
`else
        exp_null = 0;
`endif
        chk("tp4_null", 32'(total_null), 32'(exp_null));
        chk("tp4_overflow", 32'(overflow), 32'd1);

        // Reopen: totals hold; start+finish together in OPEN drains.
        start = 1'b1; step();
        chk("tp5_reopen", 32'(session), 32'd1);
        chk("tp5_totals_hold", 32'(total_null), 32'(exp_null));
        chk("tp5_ovf_clear", 32'(overflow), 32'd0);
        finish = 1'b1; step(); start = 1'b0; finish = 1'b0;
        chk("tp5_drain", 32'(session), 32'd2);
        run_to_closed();

        // Random sessions.
        for (int s = 0; s < 3; s++) begin
            start = 1'b1; step(); start = 1'b0;
            rnd_en = 1'b1;
            for (int c = 0; c < 150; c++) step();
            rnd_en = 1'b0;
            finish = 1'b1; step(); finish = 1'b0;
            run_to_closed();
        end
        for (int i = 0; i < N; i++) left[i] = 0;

        // Asynchronous reset while booth 0 holds its ack.
        start = 1'b1; step(); start = 1'b0;
        left[0] = 1; bcode[0] = 2'b01;
        step();
        chk("tp6_ack", 32'(ack), 32'b0001);
        #2 rst = 1'b1;
        #1;
        model_reset();
        left[0] = 0;
        chk("tp6_ack_drop", 32'(ack), 32'd0);
        chk("tp6_session", 32'(session), 32'd0);
        chk("tp6_totals", 32'(total_c1) + 32'(total_c2) + 32'(total_null), 32'd0);
        check_all();
        #10 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
